// File: rtl/flash_sample_reader.sv
// Fetches 32-bit words from flash over Avalon-MM and plays each out as two 16-bit samples,
// one per sample tick, pulsing changing_address once the second half has been emitted.
module flash_sample_reader #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic                address_direction,
  input  logic [ADDR_W-1:0]   reading_address,
  output logic                flash_mem_read,
  input  logic                flash_mem_waitrequest,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic [3:0]          flash_mem_byteenable,
  input  logic                flash_mem_readdatavalid,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  output logic                changing_address,
  output logic [DATA_W/2-1:0] audio_sample,
  output logic                sample_valid,
  output logic                tick_overrun
);

  localparam int unsigned HalfW = DATA_W / 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitData,
    StHalf
  } state_e;

  state_e           r_state;
  logic [HalfW-1:0] r_pending;
  logic [HalfW-1:0] w_lo;
  logic [HalfW-1:0] w_hi;

  assign w_lo                 = flash_mem_readdata[HalfW-1:0];
  assign w_hi                 = flash_mem_readdata[DATA_W-1:HalfW];
  assign flash_mem_byteenable = 4'hF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= StIdle;
      r_pending         <= '0;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      changing_address  <= 1'b0;
      audio_sample      <= '0;
      sample_valid      <= 1'b0;
      tick_overrun      <= 1'b0;
    end else begin
      sample_valid     <= 1'b0;
      changing_address <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (sample_tick) begin
            flash_mem_address <= reading_address;
            flash_mem_read    <= 1'b1;
            r_state           <= StReq;
          end
        end
        StReq: begin
          if (sample_tick) tick_overrun <= 1'b1;
          if (!flash_mem_waitrequest) begin
            flash_mem_read <= 1'b0;
            r_state        <= StWaitData;
          end
        end
        StWaitData: begin
          // A tick coincident with the data is still dropped; the data itself is kept.
          if (sample_tick) tick_overrun <= 1'b1;
          if (flash_mem_readdatavalid) begin
            // Direction is fixed here: only the half still owed is stored.
            audio_sample <= address_direction ? w_lo : w_hi;
            r_pending    <= address_direction ? w_hi : w_lo;
            sample_valid <= 1'b1;
            r_state      <= StHalf;
          end
        end
        StHalf: begin
          if (sample_tick) begin
            audio_sample     <= r_pending;
            sample_valid     <= 1'b1;
            changing_address <= 1'b1;
            r_state          <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
